// File: rtl/blur_mem_arbiter.sv
// Round-robin burst arbiter for the blurred-image row memory read port.
// Two requesters ask for runs of consecutive rows; returning data is tagged with its owner.
module blur_mem_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  input  logic              layer0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  input  logic              layer1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_layer,
  output logic              data_valid0,
  output logic              data_valid1,
  output logic              busy
);

  localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0] DrainLast = DW'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                layer_q, layer_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                sel;

  logic                gnt0_q, gnt1_q, done0_q, done1_q, mem_re_q, mem_layer_q, busy_q;
  logic                gnt0_d, gnt1_d, done0_d, done1_d, mem_re_d, mem_layer_d, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                done_any;

  // Valid pipeline mirrors the memory read latency; the last stage drives the outputs.
  logic [RD_LAT-1:0]   dv0_pipe, dv1_pipe;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    base_d  = base_q;
    layer_d = layer_q;
    owner_d = owner_q;
    last_d  = last_q;
    sel     = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins.
          sel     = (req0 && req1) ? ~last_q : req1;
          owner_d = sel;
          last_d  = sel;
          base_d  = sel ? addr1 : addr0;
          len_d   = sel ? len1 : len0;
          layer_d = sel ? layer1 : layer0;
          count_d = '0;
          dcnt_d  = '0;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          state_d = (len_d != '0) ? StBurst : StDrain;
        end
      end
      StBurst: begin
        if (count_q == len_q - LEN_W'(1)) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          count_d = count_q + LEN_W'(1);
        end
      end
      StDrain: begin
        if (dcnt_q == DrainLast) begin
          state_d = StIdle;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    mem_re_d    = (state_d == StBurst);
    mem_addr_d  = mem_re_d ? (base_d + ADDR_W'(count_d)) : '0;
    mem_layer_d = mem_re_d & layer_d;
    done_any    = (state_d == StDrain) && (dcnt_d == DrainLast);
    done0_d     = done_any & ~owner_d;
    done1_d     = done_any & owner_d;
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      len_q       <= '0;
      dcnt_q      <= '0;
      base_q      <= '0;
      layer_q     <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_layer_q <= 1'b0;
      busy_q      <= 1'b0;
      dv0_pipe    <= '0;
      dv1_pipe    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      dcnt_q      <= dcnt_d;
      base_q      <= base_d;
      layer_q     <= layer_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_layer_q <= mem_layer_d;
      busy_q      <= busy_d;
      dv0_pipe[0] <= mem_re_q & ~owner_q;
      dv1_pipe[0] <= mem_re_q & owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        dv0_pipe[i] <= dv0_pipe[i-1];
        dv1_pipe[i] <= dv1_pipe[i-1];
      end
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;
  assign mem_layer   = mem_layer_q;
  assign busy        = busy_q;
  assign data_valid0 = dv0_pipe[RD_LAT-1];
  assign data_valid1 = dv1_pipe[RD_LAT-1];

endmodule

// File: tb/tb_blur_mem_arbiter.sv
// Directed bench for blur_mem_arbiter with RD_LAT = 1; expected cycles are hand-derived.
module tb_blur_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [8:0] addr0 = '0, addr1 = '0;
  logic [4:0] len0 = '0, len1 = '0;
  logic       layer0 = 1'b0, layer1 = 1'b0;
  logic       gnt0, gnt1, done0, done1, mem_re, mem_layer, data_valid0, data_valid1, busy;
  logic [8:0] mem_addr;

  int total = 0;
  int passed = 0;

  blur_mem_arbiter #(.ADDR_W(9), .LEN_W(5), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .len0(len0), .layer0(layer0),
    .req1(req1), .addr1(addr1), .len1(len1), .layer1(layer1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_layer(mem_layer),
    .data_valid0(data_valid0), .data_valid1(data_valid1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address and layer only matter while a read is expected.
  task automatic expect_cyc(input string tag, input logic g0, input logic g1, input logic d0,
                            input logic d1, input logic re, input logic ly, input logic v0,
                            input logic v1, input logic bz, input logic [8:0] a);
    logic [17:0] o, e;
    e = {g0, g1, d0, d1, re, ly, v0, v1, bz, a};
    o = {gnt0, gnt1, done0, done1, mem_re, re ? mem_layer : 1'b0, data_valid0, data_valid1,
         busy, re ? mem_addr : 9'd0};
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h (g0 g1 d0 d1 re ly v0 v1 bz addr)", tag, o, e);
  endtask

  // Called in the sampling cycle T; returns in the next idle cycle T+len+2.
  task automatic burst(input string tag, input logic own, input logic [8:0] a, input int len,
                       input logic ly, input logic drop);
    for (int k = 1; k <= len; k++) begin
      tick();
      expect_cyc($sformatf("%s k=%0d", tag, k), k == 1 && !own, k == 1 && own, 1'b0, 1'b0,
                 1'b1, ly, k > 1 && !own, k > 1 && own, 1'b1, a + 9'(k - 1));
      if (k == 1 && drop) begin
        if (own) req1 = 1'b0;
        else req0 = 1'b0;
      end
    end
    tick();
    expect_cyc({tag, " done"}, 1'b0, 1'b0, !own, own, 1'b0, 1'b0, !own, own, 1'b1, 9'd0);
    tick();
    expect_cyc({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
  endtask

  initial begin
    tick();
    tick();
    expect_cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);

    // Single 17-row burst from requester 0.
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 9'd100; len0 = 5'd17; layer0 = 1'b1;
    burst("single", 1'b0, 9'd100, 17, 1'b1, 1'b1);

    // Zero length: grant and done together, no reads.
    req0 = 1'b1; addr0 = 9'd5; len0 = 5'd0;
    tick();
    expect_cyc("zero gnt", 1, 0, 1, 0, 0, 0, 0, 0, 1, 9'd0);
    req0 = 1'b0;
    tick();
    expect_cyc("zero idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
    tick();
    expect_cyc("zero quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);

    // Address wrap from requester 1.
    req1 = 1'b1; addr1 = 9'd508; len1 = 5'd6; layer1 = 1'b0;
    burst("wrap", 1'b1, 9'd508, 6, 1'b0, 1'b1);

    // Late req1 and addr0 change during requester 0's burst.
    req0 = 1'b1; addr0 = 9'd200; len0 = 5'd4; layer0 = 1'b0;
    tick();
    expect_cyc("late k=1", 1, 0, 0, 0, 1, 0, 0, 0, 1, 9'd200);
    req0 = 1'b0;
    tick();
    expect_cyc("late k=2", 0, 0, 0, 0, 1, 0, 1, 0, 1, 9'd201);
    req1 = 1'b1; addr1 = 9'd300; len1 = 5'd2; layer1 = 1'b1;
    addr0 = 9'd50;
    tick();
    expect_cyc("late k=3", 0, 0, 0, 0, 1, 0, 1, 0, 1, 9'd202);
    tick();
    expect_cyc("late k=4", 0, 0, 0, 0, 1, 0, 1, 0, 1, 9'd203);
    tick();
    expect_cyc("late done0", 0, 0, 1, 0, 0, 0, 1, 0, 1, 9'd0);
    tick();
    expect_cyc("late idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
    burst("late r1", 1'b1, 9'd300, 2, 1'b1, 1'b1);

    // Tie held from reset: strict alternation 0, 1, 0, 1.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 9'd10; len0 = 5'd2; layer0 = 1'b0;
    req1 = 1'b1; addr1 = 9'd20; len1 = 5'd3; layer1 = 1'b1;
    burst("rr0a", 1'b0, 9'd10, 2, 1'b0, 1'b0);
    burst("rr1a", 1'b1, 9'd20, 3, 1'b1, 1'b0);
    burst("rr0b", 1'b0, 9'd10, 2, 1'b0, 1'b0);
    burst("rr1b", 1'b1, 9'd20, 3, 1'b1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    expect_cyc("rr quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);

    // Reset at count 5 of a 17-row burst, then a tie must favour requester 0.
    req0 = 1'b1; addr0 = 9'd100; len0 = 5'd17; layer0 = 1'b1;
    tick();
    expect_cyc("rst k=1", 1, 0, 0, 0, 1, 1, 0, 0, 1, 9'd100);
    req0 = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    expect_cyc("rst k=6", 0, 0, 0, 0, 1, 1, 1, 0, 1, 9'd105);
    rst_n = 1'b1;
    tick();
    expect_cyc("rst abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 9'd40; len0 = 5'd1; layer0 = 1'b0;
    req1 = 1'b1; addr1 = 9'd60; len1 = 5'd1; layer1 = 1'b1;
    burst("post rst r0", 1'b0, 9'd40, 1, 1'b0, 1'b1);
    burst("post rst r1", 1'b1, 9'd60, 1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/blur_mem_arbiter.md
Name: blur_mem_arbiter

Overview:
- Shares the single read port of the blurred-image row memory between two burst requesters: requester 0 is the descriptor engine, requester 1 is the orientation/detector stage.
- Each request asks for a run of consecutive rows from one layer. The block arbitrates round-robin, sequences the row addresses and tags returning data with its owner.
- Sits between the requesters and the blurred-image SRAM. Its per-owner data-valid outputs act as line-buffer write enables.

Parameters:
- ADDR_W, 9, row address width.
- LEN_W, 5, burst length field width in rows.
- RD_LAT, 1, memory read latency in cycles (must be 1 or more).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1).
- req0  in  1  requester 0 burst request; level, sampled only in ST_IDLE.
- addr0  in  ADDR_W  requester 0 first row.
- len0  in  LEN_W  requester 0 row count.
- layer0  in  1  requester 0 layer select.
- req1 / addr1 / len1 / layer1  in  1 / ADDR_W / LEN_W / 1  same fields for requester 1.
- gnt0, gnt1  out  1  one-cycle grant pulse; the requester may drop req after it.
- done0, done1  out  1  one-cycle pulse, coincident with the owner's last data_valid.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory row address.
- mem_layer  out  1  layer select for the current burst.
- data_valid0, data_valid1  out  1  read data on the memory output belongs to the owner this cycle.
- busy  out  1  high whenever state is not ST_IDLE.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state ST_IDLE; last_owner = 1, so requester 0 wins the first tie; count = 0; valid pipeline cleared.
- Reset asserted mid-burst aborts immediately. No done pulse is issued, and in-flight valids are discarded.

States:
- ST_IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, select it.
  - If both are high, select the requester other than last_owner.
  - On selection: latch base address, length, layer and owner; update last_owner.
  - Next state is ST_BURST if len != 0, otherwise ST_DRAIN.
- ST_BURST:
  - mem_re = 1, mem_addr = (base + count) mod 2^ADDR_W, mem_layer = latched layer.
  - count runs 0 .. len-1.
  - When count == len-1, go to ST_DRAIN.
- ST_DRAIN:
  - Lasts exactly RD_LAT cycles; mem_re = 0.
  - done(owner) is asserted in the final DRAIN cycle, then the state returns to ST_IDLE.

Timing:
- Let T be the cycle a req is sampled in ST_IDLE.
- gnt(owner) and the first mem_re both appear at T+1.
- Reads occupy T+1 .. T+len.
- data_valid(owner) is mem_re delayed by RD_LAT, tagged with owner: T+1+RD_LAT .. T+len+RD_LAT.
- done(owner) is at T+len+RD_LAT.
- Back in ST_IDLE at T+len+RD_LAT+1. The earliest next grant is T+len+RD_LAT+2.

Other rules:
- len == 0: gnt pulses at T+1. No mem_re and no data_valid occur. done pulses at T+RD_LAT.
- Address wrap: base + count wraps modulo 2^ADDR_W. For example, base 510, len 4 reads 510, 511, 0, 1. This supports row-minus-offset underflow from requesters.
- Requests arriving while busy are ignored until ST_IDLE; a held req is served then. Request fields are sampled only at selection, so changes mid-burst have no effect.
- At most one of gnt0/gnt1, one of done0/done1 and one of data_valid0/data_valid1 is high in any cycle.
- No starvation: with both reqs held continuously, grants alternate strictly 0, 1, 0, 1, ...

Test Plan:
- Single request (RD_LAT=1): req0 with addr0=100, len0=17, layer0=1 at T.
  - gnt0 at T+1.
  - mem_addr 100..116 with mem_re high and mem_layer=1 over T+1..T+17.
  - data_valid0 over T+2..T+18, done0 at T+18.
  - busy low at T+19.
- Tie and round-robin: req0 and req1 held from reset.
  - Grant order is 0, 1, 0, 1.
  - Each new gnt comes 2 cycles after the previous done.
  - Requester 1 data_valid never overlaps requester 0's.
- Address wrap: req1 with addr1=508, len1=6.
  - mem_addr sequence 508, 509, 510, 511, 0, 1.
  - done1 coincides with the last data_valid1.
- Zero length: req0 with len0=0.
  - gnt0 at T+1 and done0 at T+1.
  - mem_re and data_valid0 stay 0.
- Late and changed request: req1 rises during requester 0's burst, and addr0 changes mid-burst.
  - Requester 0's addresses are unaffected.
  - req1 is granted 2 cycles after done0.
- Reset mid-burst: rst_n=1 at count 5 of a 17-row burst.
  - Next cycle: all outputs 0, busy 0, no done0.
  - A subsequent tie grants requester 0 first.
